// File: rtl/seq_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the sequence-scan controller slice.
//   - state_e : controller FSM states (IDLE, WAIT, SHIFT, DONE), 2-bit encoding
//   - DEF_*   : default word width, pattern width and match-counter width
// Optional feature macro used elsewhere in this slice: SEQ_SCAN_CTRL_IRQ_EN
// ----------------------------------------------------------------------------
package seq_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PAT_W  = 4;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// seq_scan_ctrl_if
// Bundles the word-side handshake, frame configuration and serial/match
// status signals of seq_scan_ctrl.
//   master : producer side (drives start/cfg/in_*; observes status)
//   slave  : controller side (seq_scan_ctrl)
// Signals: start, cfg_pattern, cfg_overlap, in_data, in_valid, in_last,
//          in_ready, bit_out, bit_valid, match_pulse, match_cnt, busy, done
// With SEQ_SCAN_CTRL_IRQ_EN defined: cfg_thresh (to slave), irq (from slave).
// ----------------------------------------------------------------------------
interface seq_scan_ctrl_if #(
  parameter int DATA_W = seq_pkg::DEF_DATA_W,
  parameter int PAT_W  = seq_pkg::DEF_PAT_W,
  parameter int CNT_W  = seq_pkg::DEF_CNT_W
);

  logic              start;
  logic [PAT_W-1:0]  cfg_pattern;
  logic              cfg_overlap;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              bit_out;
  logic              bit_valid;
  logic              match_pulse;
  logic [CNT_W-1:0]  match_cnt;
  logic              busy;
  logic              done;
`ifdef SEQ_SCAN_CTRL_IRQ_EN
  logic [CNT_W-1:0]  cfg_thresh;
  logic              irq;

  modport master (
    output start, cfg_pattern, cfg_overlap, in_data, in_valid, in_last, cfg_thresh,
    input  in_ready, bit_out, bit_valid, match_pulse, match_cnt, busy, done, irq
  );

  modport slave (
    input  start, cfg_pattern, cfg_overlap, in_data, in_valid, in_last, cfg_thresh,
    output in_ready, bit_out, bit_valid, match_pulse, match_cnt, busy, done, irq
  );
`else
  modport master (
    output start, cfg_pattern, cfg_overlap, in_data, in_valid, in_last,
    input  in_ready, bit_out, bit_valid, match_pulse, match_cnt, busy, done
  );

  modport slave (
    input  start, cfg_pattern, cfg_overlap, in_data, in_valid, in_last,
    output in_ready, bit_out, bit_valid, match_pulse, match_cnt, busy, done
  );
`endif

endinterface

// File: rtl/seq_match.sv
// ----------------------------------------------------------------------------
// seq_match
// Bit-serial pattern matcher with frame-wide history and saturating counter.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   clr_i               accepted start: latch cfg, clear history/fill/count
//   cfg_pattern_i       pattern to detect (latched on clr_i)
//   cfg_overlap_i       1 = overlapping matches allowed (latched on clr_i)
//   bit_valid_i, bit_i  serial bit stream from the controller
//   match_pulse_o       one-cycle pulse, cycle after the completing bit
//   match_cnt_o         saturating match count for the current frame
// SEQ_SCAN_CTRL_IRQ_EN adds cfg_thresh_i (latched on clr_i) and sticky irq_o.
// ----------------------------------------------------------------------------
module seq_match
  import seq_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [PAT_W-1:0] cfg_pattern_i,
  input  logic             cfg_overlap_i,
`ifdef SEQ_SCAN_CTRL_IRQ_EN
  input  logic [CNT_W-1:0] cfg_thresh_i,
  output logic             irq_o,
`endif
  input  logic             bit_valid_i,
  input  logic             bit_i,
  output logic             match_pulse_o,
  output logic [CNT_W-1:0] match_cnt_o
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pattern_q;
  logic              overlap_q;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pulse_q;
  logic              hit;
`ifdef SEQ_SCAN_CTRL_IRQ_EN
  logic [CNT_W-1:0]  thresh_q;
  logic              irq_q;
`endif

  // A match needs PAT_W bits of history since the last clear; in
  // non-overlap mode the fill restarts from zero after every hit.
  always_comb begin
    hist_d   = hist_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    hit      = 1'b0;
    fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    if (bit_valid_i) begin
      hist_d = {hist_q[PAT_W-2:0], bit_i};
      fill_d = fill_inc;
      hit    = (hist_d == pattern_q) && (fill_inc == FILL_FULL);
      if (hit) begin
        if (!overlap_q) begin
          fill_d = '0;
        end
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= '0;
      overlap_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
    end else if (clr_i) begin
      pattern_q <= cfg_pattern_i;
      overlap_q <= cfg_overlap_i;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      pulse_q   <= hit;
    end
  end

`ifdef SEQ_SCAN_CTRL_IRQ_EN
  // Sticky: compares the next count so irq rises together with match_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else if (clr_i) begin
      thresh_q <= cfg_thresh_i;
      irq_q    <= 1'b0;
    end else if ((thresh_q != '0) && (cnt_d >= thresh_q)) begin
      irq_q    <= 1'b1;
    end
  end

  assign irq_o = irq_q;
`endif

  assign match_pulse_o = pulse_q;
  assign match_cnt_o   = cnt_q;

endmodule

// File: rtl/seq_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seq_scan_ctrl
// Accepts DATA_W-bit words over valid/ready, serializes them MSB-first into
// seq_match and reports frame completion.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts any frame, no done pulse)
//   bus    seq_scan_ctrl_if.slave: start/cfg_*, in_data/in_valid/in_last,
//          in_ready, bit_out/bit_valid, match_pulse/match_cnt, busy, done
// Optional: SEQ_SCAN_CTRL_IRQ_EN adds bus.cfg_thresh and bus.irq.
// ----------------------------------------------------------------------------
module seq_scan_ctrl
  import seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_scan_ctrl_if.slave bus
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              last_q, last_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              bit_valid_q;
  logic              accept_start;

  assign accept_start = (state_q == IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      last_q      <= 1'b0;
      idx_q       <= '0;
      bit_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      bit_valid_q <= (state_d == SHIFT);
    end
  end

  // The captured word shifts left each SHIFT cycle so its MSB flop is the
  // serial output directly; idx_q only counts the remaining bits.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.in_valid) begin
          word_d  = bus.in_data;
          last_d  = bus.in_last;
          idx_d   = IDX_W'(DATA_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        word_d = word_q << 1;
        idx_d  = idx_q - IDX_W'(1);
        if (idx_q == '0) begin
          state_d = last_q ? DONE : WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == WAIT);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.bit_valid = bit_valid_q;
  assign bus.bit_out   = word_q[DATA_W-1];

  seq_match #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) u_match (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_i         (accept_start),
    .cfg_pattern_i (bus.cfg_pattern),
    .cfg_overlap_i (bus.cfg_overlap),
`ifdef SEQ_SCAN_CTRL_IRQ_EN
    .cfg_thresh_i  (bus.cfg_thresh),
    .irq_o         (bus.irq),
`endif
    .bit_valid_i   (bit_valid_q),
    .bit_i         (word_q[DATA_W-1]),
    .match_pulse_o (bus.match_pulse),
    .match_cnt_o   (bus.match_cnt)
  );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seq_scan_ctrl
// Drives two seq_scan_ctrl instances with identical stimulus: dutA with the
// default 8-bit counter and dutB with a 2-bit counter (saturates at 3).
// Expected outputs come from a frame-level model: the frame's bit stream is
// scanned window by window for the pattern, and the per-cycle timeline
// (WAIT / SHIFT / DONE) is laid out by the driver from the words it sends.
// Optional feature macro: SEQ_SCAN_CTRL_IRQ_EN (irq checks enabled).
// ----------------------------------------------------------------------------
module tb_seq_scan_ctrl;

   localparam int DATA_W = 8;
   localparam int PAT_W  = 4;
   localparam int CNT_W  = 8;
   localparam int SCNT_W = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   seq_scan_ctrl_if #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W))  busA ();
   seq_scan_ctrl_if #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(SCNT_W)) busB ();

   seq_scan_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dutA (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busA)
   );

   seq_scan_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(SCNT_W)) dutB (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busB)
   );

   int vectors = 0;
   int miscompares = 0;

   // Expected values for the current cycle, set right after each rising edge
   logic checkEn = 1'b0;
   logic expReady = 1'b0;
   logic expBitValid = 1'b0;
   logic expBitOut = 1'b0;
   logic expBusy = 1'b0;
   logic expDone = 1'b0;
   logic expPulse = 1'b0;
   int   expCnt = 0;
   int   expThresh = 0;

   // Frame description and model results
   logic [DATA_W-1:0] frameWords [0:7];
   int                frameGaps [0:7];
   int                nWords = 0;
   int                nBits = 0;
   logic              streamBits [0:63];
   logic              matchAt [0:63];

   function automatic int satTo(input int v, input int maxV);
      return (v > maxV) ? maxV : v;
   endfunction

   // Greedy window scan: a window ending at k matches when it equals the
   // pattern, and without overlap it must start after the previous match.
   function automatic void buildModel(input logic [PAT_W-1:0] pat, input logic ovl);
      int lastEnd;
      logic [PAT_W-1:0] win;
      nBits = nWords * DATA_W;
      for (int w = 0; w < nWords; w++)
         for (int b = 0; b < DATA_W; b++)
            streamBits[w*DATA_W+b] = frameWords[w][DATA_W-1-b];
      for (int k = 0; k < 64; k++) matchAt[k] = 1'b0;
      lastEnd = -1;
      for (int k = PAT_W - 1; k < nBits; k++) begin
         win = '0;
         for (int j = 0; j < PAT_W; j++) win = {win[PAT_W-2:0], streamBits[k-PAT_W+1+j]};
         if (win == pat && (ovl || (k - PAT_W + 1 > lastEnd))) begin
            matchAt[k] = 1'b1;
            lastEnd = k;
         end
      end
   endfunction

   function automatic int countMatches();
      int n = 0;
      for (int k = 0; k < nBits; k++) if (matchAt[k]) n++;
      return n;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic [PAT_W-1:0] pat, input logic ovl,
                                input int th, input logic [DATA_W-1:0] data,
                                input logic vld, input logic lst);
      busA.start = st;  busA.cfg_pattern = pat; busA.cfg_overlap = ovl;
      busA.in_data = data; busA.in_valid = vld; busA.in_last = lst;
      busB.start = st;  busB.cfg_pattern = pat; busB.cfg_overlap = ovl;
      busB.in_data = data; busB.in_valid = vld; busB.in_last = lst;
`ifdef SEQ_SCAN_CTRL_IRQ_EN
      busA.cfg_thresh = CNT_W'(th);
      busB.cfg_thresh = SCNT_W'(th);
`else
      if (th < 0) $display("[TB] negative threshold ignored");
`endif
   endtask

   // Random start/cfg/data/last; everything but the valid level is junk
   task automatic applyJunk(input logic vld);
      applyStimulus(1'($urandom_range(0, 1)), PAT_W'($urandom), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 7)), DATA_W'($urandom), vld, 1'($urandom_range(0, 1)));
   endtask

   task automatic setExp(input logic rdy, input logic bv, input logic bo,
                         input logic bsy, input logic dn, input logic pl);
      expReady = rdy; expBitValid = bv; expBitOut = bo;
      expBusy = bsy; expDone = dn; expPulse = pl;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Compare every cycle, mid-cycle, against the expected values
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("in_ready_A", busA.in_ready, expReady);
         checkOutput("in_ready_B", busB.in_ready, expReady);
         checkOutput("bit_valid_A", busA.bit_valid, expBitValid);
         checkOutput("bit_valid_B", busB.bit_valid, expBitValid);
         if (expBitValid) begin
            checkOutput("bit_out_A", busA.bit_out, expBitOut);
            checkOutput("bit_out_B", busB.bit_out, expBitOut);
         end
         checkOutput("busy_A", busA.busy, expBusy);
         checkOutput("busy_B", busB.busy, expBusy);
         checkOutput("done_A", busA.done, expDone);
         checkOutput("done_B", busB.done, expDone);
         checkOutput("match_pulse_A", busA.match_pulse, expPulse);
         checkOutput("match_pulse_B", busB.match_pulse, expPulse);
         checkOutput("match_cnt_A", busA.match_cnt, satTo(expCnt, (1 << CNT_W) - 1));
         checkOutput("match_cnt_B", busB.match_cnt, satTo(expCnt, (1 << SCNT_W) - 1));
`ifdef SEQ_SCAN_CTRL_IRQ_EN
         checkOutput("irq_A", busA.irq,
                     (expThresh != 0 && satTo(expCnt, (1 << CNT_W) - 1) >= expThresh) ? 1 : 0);
         checkOutput("irq_B", busB.irq,
                     ((expThresh % 4) != 0 && satTo(expCnt, 3) >= (expThresh % 4)) ? 1 : 0);
`endif
      end
   end

   // Mid-frame asynchronous reset: outputs must drop without waiting for a clock
   task automatic doAbort();
      checkEn = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy_A", busA.busy, 0);
      checkOutput("abort_bit_valid_A", busA.bit_valid, 0);
      checkOutput("abort_bit_out_A", busA.bit_out, 0);
      checkOutput("abort_pulse_A", busA.match_pulse, 0);
      checkOutput("abort_done_A", busA.done, 0);
      checkOutput("abort_cnt_A", busA.match_cnt, 0);
      checkOutput("abort_in_ready_B", busB.in_ready, 0);
      checkOutput("abort_cnt_B", busB.match_cnt, 0);
`ifdef SEQ_SCAN_CTRL_IRQ_EN
      checkOutput("abort_irq_A", busA.irq, 0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 0, '0, 1'b0, 1'b0);
      setExp(0, 0, 0, 0, 0, 0);
      expCnt = 0;
      expThresh = 0;
      checkEn = 1'b1;
   endtask

   // One frame: accepted start, then per word a few idle WAIT cycles, the
   // handshake cycle and DATA_W SHIFT cycles, then DONE and one IDLE cycle.
   task automatic runFrame(input logic [PAT_W-1:0] pat, input logic ovl, input int th,
                           input logic holdValid, input int abortBit);
      int shown;
      int cntTrue;
      logic pend;
      buildModel(pat, ovl);
      stepCycle();
      applyStimulus(1'b1, pat, ovl, th, DATA_W'($urandom), 1'b0, 1'b0);
      setExp(0, 0, 0, 0, 0, 0);
      shown = 0;
      cntTrue = 0;
      pend = 1'b0;
      for (int w = 0; w < nWords; w++) begin
         for (int g = 0; g < frameGaps[w]; g++) begin
            stepCycle();
            applyJunk(1'b0);
            setExp(1, 0, 0, 1, 0, pend);
            expCnt = cntTrue;
            expThresh = th;
            pend = 1'b0;
         end
         stepCycle();
         applyStimulus(1'($urandom_range(0, 1)), PAT_W'($urandom), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 7)), frameWords[w], 1'b1, (w == nWords - 1));
         setExp(1, 0, 0, 1, 0, pend);
         expCnt = cntTrue;
         expThresh = th;
         pend = 1'b0;
         for (int b = 0; b < DATA_W; b++) begin
            stepCycle();
            applyJunk(holdValid ? 1'b1 : 1'($urandom_range(0, 1)));
            setExp(0, 1, streamBits[shown], 1, 0, pend);
            expCnt = cntTrue;
            if (shown == abortBit) begin
               doAbort();
               return;
            end
            pend = matchAt[shown];
            if (pend) cntTrue++;
            shown++;
         end
      end
      stepCycle();
      applyJunk(1'($urandom_range(0, 1)));
      setExp(0, 0, 0, 1, 1, pend);
      expCnt = cntTrue;
      stepCycle();
      applyStimulus(1'b0, '0, 1'b0, 0, '0, 1'b0, 1'b0);
      setExp(0, 0, 0, 0, 0, 0);
   endtask

   task automatic loadOneWord(input logic [DATA_W-1:0] w0);
      nWords = 1;
      frameWords[0] = w0;
      frameGaps[0] = 0;
   endtask

   initial begin
      applyStimulus(1'b0, '0, 1'b0, 0, '0, 1'b0, 1'b0);
      setExp(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy", busA.busy, 0);
      checkOutput("reset_in_ready", busA.in_ready, 0);
      checkOutput("reset_bit_valid", busA.bit_valid, 0);
      checkOutput("reset_done", busA.done, 0);
      checkOutput("reset_cnt", busA.match_cnt, 0);
      rst_n = 1'b1;
      checkEn = 1'b1;

      $display("[TB] overlap frame");
      loadOneWord(8'b1011_0110);
      runFrame(4'b1011, 1'b1, 2, 1'b1, -1);
      checkOutput("t1_model_count", countMatches(), 2);
      checkOutput("t1_model_bit3", matchAt[3], 1);
      checkOutput("t1_model_bit6", matchAt[6], 1);
      checkOutput("t1_cnt", busA.match_cnt, 2);
`ifdef SEQ_SCAN_CTRL_IRQ_EN
      checkOutput("t1_irq", busA.irq, 1);
`endif

      $display("[TB] non-overlap frame");
      loadOneWord(8'b1011_0110);
      runFrame(4'b1011, 1'b0, 0, 1'b1, -1);
      checkOutput("t2_model_count", countMatches(), 1);
      checkOutput("t2_model_bit3", matchAt[3], 1);
      checkOutput("t2_cnt", busA.match_cnt, 1);

      $display("[TB] straddling match");
      nWords = 2;
      frameWords[0] = 8'b0000_0101;
      frameWords[1] = 8'b1000_0000;
      frameGaps[0] = 0;
      frameGaps[1] = 0;
      runFrame(4'b1011, 1'b1, 0, 1'b1, -1);
      checkOutput("t3_model_count", countMatches(), 1);
      checkOutput("t3_model_bit8", matchAt[8], 1);
      checkOutput("t3_cnt", busA.match_cnt, 1);

      $display("[TB] counter saturation");
      loadOneWord(8'hFF);
      runFrame(4'b1111, 1'b1, 0, 1'b0, -1);
      checkOutput("t4_model_count", countMatches(), 5);
      checkOutput("t4_cnt_A", busA.match_cnt, 5);
      checkOutput("t4_cnt_B", busB.match_cnt, 3);

      $display("[TB] backpressure with valid held");
      nWords = 2;
      frameWords[0] = 8'b0110_0110;
      frameWords[1] = 8'b1100_1101;
      frameGaps[0] = 1;
      frameGaps[1] = 2;
      runFrame(4'b0110, 1'b0, 1, 1'b1, -1);

      $display("[TB] reset mid-shift, then fresh frame");
      loadOneWord(8'b1011_0110);
      runFrame(4'b1011, 1'b1, 2, 1'b1, 5);
      loadOneWord(8'b1011_0110);
      runFrame(4'b1011, 1'b1, 2, 1'b1, -1);
      checkOutput("t6_cnt", busA.match_cnt, 2);

      $display("[TB] random frames");
      for (int f = 0; f < 40; f++) begin
         nWords = int'($urandom_range(1, 4));
         for (int w = 0; w < nWords; w++) begin
            frameWords[w] = DATA_W'($urandom);
            frameGaps[w] = int'($urandom_range(0, 2));
         end
         runFrame(PAT_W'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nWords * DATA_W - 1)) : -1);
      end

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
